fb_writer: RTL and testbench

// - Write side of the 50x50 greyscale frame memory that the video generator reads.
// - Loads a full frame in raster order from a valid/ready pixel byte stream, or

---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_raster_cnt.sv | 69 ++++++
 rtl/fb_writer.sv | 137 +++++++++++++
 tb/tb_fb_writer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and frame geometry for the frame-buffer write side.
package fb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FILL  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } fb_state_t;

  localparam int FB_W      = 50;
  localparam int FB_H      = 50;
  localparam int FB_PIXELS = FB_W * FB_H;

  function automatic logic fb_is_busy(input fb_state_t s);
    case (s)
      LOAD, FILL, FLUSH: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fb_raster_cnt.sv
// Raster position counter: col/row plus a row base that steps by IMG_W,
// so the word address is formed with an adder instead of a multiplier.
module fb_raster_cnt #(
  parameter int IMG_W = 50,
  parameter int IMG_H = 50,
  parameter int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] base_q, base_d;
  logic          col_end_s;

  assign col_end_s = (col_q == CW'(IMG_W - 1));
  assign last_o    = col_end_s && (row_q == RW'(IMG_H - 1));
  assign addr_o    = base_q + AW'(col_q);

  // Next position: clear, wrap at end of frame, wrap at end of row, or step.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    if (clr_i) begin
      col_d  = CW'(0);
      row_d  = RW'(0);
      base_d = AW'(0);
    end else if (inc_i) begin
      if (last_o) begin
        col_d  = CW'(0);
        row_d  = RW'(0);
        base_d = AW'(0);
      end else if (col_end_s) begin
        col_d  = CW'(0);
        row_d  = row_q + RW'(1);
        base_d = base_q + AW'(IMG_W);
      end else begin
        col_d  = col_q + CW'(1);
      end
    end else begin
      col_d  = col_q;
      row_d  = row_q;
      base_d = base_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= CW'(0);
      row_q  <= RW'(0);
      base_q <= AW'(0);
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Frame-buffer writer: loads a raster-order pixel stream or fills the frame
// with a constant, driving a registered memory write port.
module fb_writer
  import fb_pkg::*;
#(
  parameter int IMG_W  = FB_W,
  parameter int IMG_H  = FB_H,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fill_en,
  input  logic [7:0]        fill_value,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] DataAdr,
  output logic [DATA_W-1:0] WriteData,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(IMG_W * IMG_H);

  fb_state_t     state_q, state_d;
  logic [7:0]    fill_q, fill_d;
  logic          mw_q, mw_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [7:0]    pix_q, pix_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cnt_clr_s, cnt_inc_s, cnt_last_s;
  logic [AW-1:0] cnt_addr_s;

  fb_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr_s),
    .inc_i  (cnt_inc_s),
    .addr_o (cnt_addr_s),
    .last_o (cnt_last_s)
  );

  // Next state, counter control and next write-port values.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    mw_d      = 1'b0;
    adr_d     = adr_q;
    pix_d     = pix_q;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    pix_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr_s = 1'b1;
          fill_d    = fill_value;
          state_d   = fill_en ? FILL : LOAD;
        end else begin
          state_d   = IDLE;
        end
      end
      LOAD: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          mw_d      = 1'b1;
          adr_d     = cnt_addr_s;
          pix_d     = pix_data;
          cnt_inc_s = 1'b1;
          state_d   = cnt_last_s ? FLUSH : LOAD;
        end else begin
          state_d   = LOAD;
        end
      end
      FILL: begin
        mw_d      = 1'b1;
        adr_d     = cnt_addr_s;
        pix_d     = fill_q;
        cnt_inc_s = 1'b1;
        if (cnt_last_s) begin
          state_d = FLUSH;
        end else begin
          state_d = FILL;
        end
      end
      // The last write is already in the output registers; let it be seen.
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = fb_is_busy(state_d);
    done_d = (state_d == DONE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write-port, status and fill-value registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= 8'h00;
      mw_q   <= 1'b0;
      adr_q  <= AW'(0);
      pix_q  <= 8'h00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      mw_q   <= mw_d;
      adr_q  <= adr_d;
      pix_q  <= pix_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign MemWrite  = mw_q;
  assign DataAdr   = {{(ADDR_W - AW){1'b0}}, adr_q};
  assign WriteData = {{(DATA_W - 8){1'b0}}, pix_q};
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: reset, LOAD (with and without bubbles), FILL,
// start while busy, and reset mid-LOAD.
module tb_fb_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        fill_en;
  logic [7:0]  fill_value;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  fb_writer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .fill_en    (fill_en),
    .fill_value (fill_value),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_memwrite"}, 32'(MemWrite), 32'd0);
    chk({tag, "_adr"}, DataAdr, 32'd0);
    chk({tag, "_wdata"}, WriteData, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
  endtask

  // One LOAD frame; optional extra start pulse and optional mid-frame reset.
  task automatic run_load(input int bubble_pct, input int start_at, input int abort_at);
    int beats, writes, dones, k, last_k;
    bit prev_beat, beat_now, finished, start_sent;
    beats = 0; writes = 0; dones = 0; k = 0; last_k = -10;
    prev_beat = 1'b0; finished = 1'b0; start_sent = 1'b0;
    @(negedge clk);
    start = 1'b1; fill_en = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!finished && k < 20000 && errors < 20) begin
      chk("ld_ready", 32'(pix_ready), 32'(beats < 2500));
      chk("ld_memwrite", 32'(MemWrite), 32'(prev_beat));
      if (MemWrite) begin
        chk("ld_adr", DataAdr, 32'(writes));
        chk("ld_data", WriteData, {24'h000000, 8'(writes)});
        if (abort_at == writes) begin
          #2 reset = 1'b1;
          #1 check_zero("rst_mid");
          @(negedge clk);
          reset = 1'b0; pix_valid = 1'b0;
          repeat (5) begin
            @(negedge clk);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_memwrite", 32'(MemWrite), 32'd0);
          end
          finished = 1'b1;
        end
        writes++;
      end
      if (!finished) begin
        chk("ld_done", 32'(done), 32'(k == last_k + 2));
        chk("ld_busy", 32'(busy), 32'((beats < 2500) || (k == last_k + 1)));
        if (done) dones++;
        if (k == last_k + 3) begin
          finished = 1'b1;
        end else begin
          if (start_at >= 0 && writes >= start_at && !start_sent) begin
            start = 1'b1; fill_en = 1'b1; start_sent = 1'b1;
          end else begin
            start = 1'b0;
          end
          pix_valid = ($urandom_range(99) >= 32'(bubble_pct));
          pix_data  = 8'(beats);
          beat_now  = pix_valid && (beats < 2500);
          if (beat_now) begin
            beats++;
            if (beats == 2500) last_k = k;
          end
          prev_beat = beat_now;
          k++;
          @(negedge clk);
        end
      end
    end
    start = 1'b0; pix_valid = 1'b0;
    if (abort_at < 0) begin
      chk("ld_writes", 32'(writes), 32'd2500);
      chk("ld_dones", 32'(dones), 32'd1);
    end
  endtask

  // One FILL frame of 8'hA5; pixels are offered throughout but must not be taken.
  task automatic run_fill();
    int writes, dones;
    writes = 0; dones = 0;
    @(negedge clk);
    start = 1'b1; fill_en = 1'b1; fill_value = 8'hA5; pix_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; fill_value = 8'h3C;
    for (int k = 0; k <= 2502 && errors < 20; k++) begin
      chk("fl_ready", 32'(pix_ready), 32'd0);
      chk("fl_memwrite", 32'(MemWrite), 32'(k >= 1 && k <= 2500));
      if (MemWrite) begin
        chk("fl_adr", DataAdr, 32'(writes));
        chk("fl_data", WriteData, 32'h000000A5);
        writes++;
      end
      chk("fl_done", 32'(done), 32'(k == 2501));
      chk("fl_busy", 32'(busy), 32'(k <= 2500));
      if (done) dones++;
      @(negedge clk);
    end
    pix_valid = 1'b0; fill_en = 1'b0;
    chk("fl_writes", 32'(writes), 32'd2500);
    chk("fl_dones", 32'(dones), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; fill_en = 1'b0; fill_value = 8'h00;
    pix_valid = 1'b0; pix_data = 8'h00;
    #1 check_zero("rst_init");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pix_valid = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(pix_ready), 32'd0);
    chk("idle_memwrite", 32'(MemWrite), 32'd0);
    pix_valid = 1'b0;

    run_load(0, -1, -1);
    run_load(30, -1, -1);
    run_fill();
    run_load(0, 1000, -1);
    run_load(0, -1, 700);
    run_load(0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
